// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, register map, defaults.
package irq_ctrl_pkg;

    localparam int unsigned NSRC_DEFAULT = 8;
    localparam int unsigned ADDR_W       = 2;
    localparam int unsigned DATA_W       = 32;

    localparam logic [ADDR_W-1:0] ADDR_PEND = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_MASK = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_MODE = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_EOI  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: index of the lowest set request bit plus a valid flag.
module irq_prio_enc #(
    parameter int unsigned NSRC = 8,
    parameter int unsigned IDW  = 3
) (
    input  logic [NSRC-1:0] req,
    output logic            valid,
    output logic [IDW-1:0]  idx
);

    // Scan from the top down so the lowest set index is the last to assign.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronizes sources, keeps PEND/MASK(/MODE) registers,
// selects the lowest eligible source and runs the IDLE/REQ/SERVICE handshake.
// Define IRQ_CTRL_EDGE_EN to add the MODE register and edge-triggered sources.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned NSRC = NSRC_DEFAULT,
    parameter int unsigned IDW  = $clog2(NSRC)
) (
    input  logic                clk,
    input  logic                RESET,
    input  logic [NSRC-1:0]     irq_src,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    input  logic                irq_ack,
    output logic                IRQ,
    output logic [IDW-1:0]      irq_id,
    output logic                in_service
);

    logic [NSRC-1:0] sync1_q, sync2_q;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] mode;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] wdata_src;
    logic            wr_pend, wr_mask, wr_mode, wr_eoi;
    logic            sel_valid;
    logic [IDW-1:0]  sel_id;
    logic            ack_take;
    logic            unused_wdata;

    irq_state_e      state_q, state_d;
    logic            irq_q, irq_d;
    logic [IDW-1:0]  irq_id_q, irq_id_d;
    logic            in_service_q, in_service_d;

    assign wdata_src    = wr_data[NSRC-1:0];
    assign unused_wdata = ^wr_data;
    assign wr_pend      = wr_en && (wr_addr == ADDR_PEND);
    assign wr_mask      = wr_en && (wr_addr == ADDR_MASK);
    assign wr_mode      = wr_en && (wr_addr == ADDR_MODE);
    assign wr_eoi       = wr_en && (wr_addr == ADDR_EOI);
    assign ack_take     = (state_q == ST_REQ) && irq_ack;

    // Two-flop synchronizer on every raw request line.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_src;
            sync2_q <= sync1_q;
        end
    end

`ifdef IRQ_CTRL_EDGE_EN
    logic [NSRC-1:0] mode_q, mode_d;
    logic [NSRC-1:0] sync_prev_q;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] clr;

    // MODE register and the previous synchronized level for rising-edge detection.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            mode_q      <= '0;
            sync_prev_q <= '0;
        end else begin
            mode_q      <= mode_d;
            sync_prev_q <= sync2_q;
        end
    end

    // MODE write path.
    always_comb begin
        mode_d = mode_q;
        if (wr_mode) begin
            mode_d = wdata_src;
        end
    end

    assign mode = mode_q;
    assign rise = sync2_q & ~sync_prev_q;

    // Edge bits: sticky, cleared by W1C or by taking the trap; a new edge beats the clear.
    always_comb begin
        clr = '0;
        if (wr_pend) begin
            clr = wdata_src;
        end
        if (ack_take) begin
            clr = clr | (NSRC'(1) << irq_id_q);
        end
        pend_d = (mode & ((pend_q & ~clr) | rise)) | (~mode & sync2_q);
    end
`else
    assign mode = '0;

    // All sources are level: PEND simply follows the synchronized request.
    always_comb begin
        pend_d = sync2_q;
    end
`endif

    // MASK write path.
    always_comb begin
        mask_d = mask_q;
        if (wr_mask) begin
            mask_d = wdata_src;
        end
    end

    // PEND and MASK registers.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            pend_q <= '0;
            mask_q <= '0;
        end else begin
            pend_q <= pend_d;
            mask_q <= mask_d;
        end
    end

    assign eligible = pend_q & mask_q;

    irq_prio_enc #(
        .NSRC (NSRC),
        .IDW  (IDW)
    ) u_prio_enc (
        .req   (eligible),
        .valid (sel_valid),
        .idx   (sel_id)
    );

    // Request handshake: next state and registered outputs.
    always_comb begin
        state_d      = state_q;
        irq_d        = irq_q;
        irq_id_d     = irq_id_q;
        in_service_d = in_service_q;
        unique case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    state_d  = ST_REQ;
                    irq_d    = 1'b1;
                    irq_id_d = sel_id;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    state_d      = ST_SERVICE;
                    irq_d        = 1'b0;
                    in_service_d = 1'b1;
                end else if (!eligible[irq_id_q]) begin
                    state_d = ST_IDLE;
                    irq_d   = 1'b0;
                end
            end
            ST_SERVICE: begin
                if (wr_eoi) begin
                    state_d      = ST_IDLE;
                    in_service_d = 1'b0;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                irq_d        = 1'b0;
                in_service_d = 1'b0;
            end
        endcase
    end

    // FSM state and output registers.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q      <= ST_IDLE;
            irq_q        <= 1'b0;
            irq_id_q     <= '0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            irq_q        <= irq_d;
            irq_id_q     <= irq_id_d;
            in_service_q <= in_service_d;
        end
    end

    // Combinational register read, zero-extended; EOI reads as zero.
    always_comb begin
        rd_data = '0;
        unique case (rd_addr)
            ADDR_PEND: rd_data = DATA_W'(pend_q);
            ADDR_MASK: rd_data = DATA_W'(mask_q);
            ADDR_MODE: rd_data = DATA_W'(mode);
            default:   rd_data = '0;
        endcase
    end

    assign IRQ        = irq_q;
    assign irq_id     = irq_id_q;
    assign in_service = in_service_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl (level path always, edge path with IRQ_CTRL_EDGE_EN).
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    localparam int unsigned NSRC = 8;
    localparam int unsigned IDW  = 3;

    logic              clk = 1'b0;
    logic              RESET;
    logic [NSRC-1:0]   irq_src;
    logic              wr_en;
    logic [1:0]        wr_addr;
    logic [31:0]       wr_data;
    logic [1:0]        rd_addr;
    logic [31:0]       rd_data;
    logic              irq_ack;
    logic              IRQ;
    logic [IDW-1:0]    irq_id;
    logic              in_service;

    int n_checks = 0;
    int n_errors = 0;

    irq_ctrl #(
        .NSRC (NSRC),
        .IDW  (IDW)
    ) dut (
        .clk        (clk),
        .RESET      (RESET),
        .irq_src    (irq_src),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .irq_ack    (irq_ack),
        .IRQ        (IRQ),
        .irq_id     (irq_id),
        .in_service (in_service)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
        wr_data = '0;
    endtask

    task automatic rd_check(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        rd_addr = addr;
        #1;
        check(tag, rd_data, exp);
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    initial begin
        RESET   = 1'b0;
        irq_src = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        irq_ack = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_irq", 32'(IRQ), 32'd0);
        check("rst_id", 32'(irq_id), 32'd0);
        check("rst_insvc", 32'(in_service), 32'd0);
        rd_check("rst_mask", ADDR_MASK, 32'd0);
        RESET = 1'b1;
        tick();

        // Level source 0: three-edge latency to IRQ, ack, EOI, re-request
        wr(ADDR_MASK, 32'h01);
        irq_src = 8'h01;
        tick();
        tick();
        check("lvl_irq_e1", 32'(IRQ), 32'd0);
        tick();
        rd_check("lvl_pend_e2", ADDR_PEND, 32'h01);
        check("lvl_irq_e2", 32'(IRQ), 32'd0);
        tick();
        check("lvl_irq_e3", 32'(IRQ), 32'd1);
        check("lvl_id", 32'(irq_id), 32'd0);
        ack();
        check("lvl_ack_irq", 32'(IRQ), 32'd0);
        check("lvl_ack_insvc", 32'(in_service), 32'd1);
        tick();
        check("lvl_svc_irq", 32'(IRQ), 32'd0);
        wr(ADDR_EOI, 32'h0);
        check("lvl_eoi_insvc", 32'(in_service), 32'd0);
        check("lvl_eoi_irq", 32'(IRQ), 32'd0);
        tick();
        check("lvl_rereq_irq", 32'(IRQ), 32'd1);

        // Drain: drop source, take the trap, let PEND fall, then EOI
        irq_src = '0;
        ack();
        repeat (3) tick();
        wr(ADDR_EOI, 32'h0);
        repeat (3) tick();
        check("drain_irq", 32'(IRQ), 32'd0);
        check("drain_insvc", 32'(in_service), 32'd0);

        // Stray ack in IDLE
        ack();
        check("stray_ack_irq", 32'(IRQ), 32'd0);
        check("stray_ack_insvc", 32'(in_service), 32'd0);
        rd_check("stray_ack_pend", ADDR_PEND, 32'h00);

        // Priority: sources 4 and 5 together, 4 wins
        wr(ADDR_MASK, 32'hFF);
        irq_src = 8'h30;
        repeat (4) tick();
        check("prio_irq", 32'(IRQ), 32'd1);
        check("prio_id4", 32'(irq_id), 32'd4);
        rd_check("prio_pend", ADDR_PEND, 32'h30);
        wr(ADDR_EOI, 32'h0);
        check("stray_eoi_irq", 32'(IRQ), 32'd1);
        check("stray_eoi_id", 32'(irq_id), 32'd4);
        check("stray_eoi_insvc", 32'(in_service), 32'd0);
        ack();
        check("prio_insvc", 32'(in_service), 32'd1);
        irq_src = 8'h20;
        repeat (3) tick();
        check("prio_svc_id", 32'(irq_id), 32'd4);
        rd_check("prio_pend_drop", ADDR_PEND, 32'h20);
        wr(ADDR_EOI, 32'h0);
        tick();
        check("prio_irq5", 32'(IRQ), 32'd1);
        check("prio_id5", 32'(irq_id), 32'd5);

        // Level drop while requesting returns to IDLE
        irq_src = '0;
        repeat (5) tick();
        check("drop_irq", 32'(IRQ), 32'd0);

        // Withdrawal by masking while in REQ
        irq_src = 8'h04;
        repeat (4) tick();
        check("wd_irq", 32'(IRQ), 32'd1);
        check("wd_id", 32'(irq_id), 32'd2);
        wr(ADDR_MASK, 32'h00);
        tick();
        check("wd_irq_off", 32'(IRQ), 32'd0);
        ack();
        check("wd_no_ack", 32'(in_service), 32'd0);
        check("wd_irq_after", 32'(IRQ), 32'd0);
        rd_check("wd_pend", ADDR_PEND, 32'h04);

        // Asynchronous reset in SERVICE
        wr(ADDR_MASK, 32'h04);
        tick();
        check("rs_irq", 32'(IRQ), 32'd1);
        ack();
        check("rs_insvc", 32'(in_service), 32'd1);
        #2;
        RESET = 1'b0;
        #1;
        check("rs_async_irq", 32'(IRQ), 32'd0);
        check("rs_async_insvc", 32'(in_service), 32'd0);
        rd_check("rs_async_mask", ADDR_MASK, 32'h00);
        tick();
        tick();
        RESET = 1'b1;
        repeat (5) tick();
        check("rs_post_irq", 32'(IRQ), 32'd0);
        check("rs_post_insvc", 32'(in_service), 32'd0);
        rd_check("rs_post_pend", ADDR_PEND, 32'h04);
        rd_check("rs_post_mode", ADDR_MODE, 32'h00);

        // W1C has no effect on a level source
        wr(ADDR_PEND, 32'h04);
        rd_check("lvl_w1c", ADDR_PEND, 32'h04);

`ifndef IRQ_CTRL_EDGE_EN
        // Without edge support MODE is read-only zero
        wr(ADDR_MODE, 32'hFF);
        rd_check("mode_ro", ADDR_MODE, 32'h00);
`else
        // Edge source 1: pulse is captured and held, ack clears, set beats W1C
        irq_src = '0;
        repeat (4) tick();
        wr(ADDR_MODE, 32'h02);
        rd_check("edge_mode", ADDR_MODE, 32'h02);
        wr(ADDR_MASK, 32'h02);
        irq_src = 8'h02;
        tick();
        irq_src = '0;
        tick();
        tick();
        rd_check("edge_pend_set", ADDR_PEND, 32'h02);
        repeat (2) tick();
        rd_check("edge_pend_hold", ADDR_PEND, 32'h02);
        check("edge_irq", 32'(IRQ), 32'd1);
        check("edge_id", 32'(irq_id), 32'd1);
        ack();
        rd_check("edge_ack_clr", ADDR_PEND, 32'h00);
        check("edge_insvc", 32'(in_service), 32'd1);
        wr(ADDR_EOI, 32'h0);
        wr(ADDR_MASK, 32'h00);
        check("edge_eoi_insvc", 32'(in_service), 32'd0);
        irq_src = 8'h02;
        tick();
        irq_src = '0;
        tick();
        wr(ADDR_PEND, 32'h02);
        rd_check("edge_set_wins", ADDR_PEND, 32'h02);
        wr(ADDR_PEND, 32'h02);
        rd_check("edge_w1c", ADDR_PEND, 32'h00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
